prbs5_checker: RTL and testbench
================================

Name: prbs5_checker

Overview:
- Serial receive-side checker for the 5-bit LFSR pattern generator, i.e. polynomial x^5+x^2+1, period 31.
- The generator's serial output is its state bit 0 each clock; the stream obeys b[n] = b[n-3] ^ b[n-5].
- The block self-synchronises to that stream, declares lock, then counts bit errors against a free-running local prediction.
- Sits at the end of a loopback or serial link path for BER testing.

Parameters:
- BITWIDTH, 5, history register width; fixed at 5 for this polynomial, other values unsupported.
- LOCK_CNT, 8, consecutive correct predictions needed in HUNT to enter LOCK (range 1..255).
- UNLOCK_ERR, 4, errors within one 31-bit LOCK window that force loss of lock (range 1..31).
- ERR_CNT_W, 16, err_count width.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous active-low reset.
- bit_valid  input  1  bit_in is sampled this cycle when high.
- bit_in  input  1  received serial bit.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  registered; high while in LOCK.
- err_pulse  output  1  registered one-cycle pulse per errored bit while locked.
- err_count  output  ERR_CNT_W  saturating error counter.

Behaviour:
- Reset (async, arst_n low): state=FILL, H=0, fill_cnt=0, match_cnt=0, win_cnt=0, win_err=0, locked=0, err_pulse=0, err_count=0.
- H[4:0] is the history register. H[4] is the newest bit, H[0] the oldest.
- Prediction p = H[2]^H[0].
- All updates occur only on cycles with bit_valid=1, except err_pulse and clr_cnt. err_pulse is forced to 0 on any cycle without an error. Outputs reflect a bit one clock after it is sampled.
- FILL:
  - H <= {bit_in, H[4:1]}; fill_cnt++.
  - When the 5th bit is shifted in, go to HUNT with match_cnt=0.
- HUNT:
  - Compare bit_in with p. H <= {bit_in, H[4:1]} regardless of the result.
  - Match and H!=0: match_cnt++.
  - Mismatch, or H==0: match_cnt=0. This means an all-zero stream never locks.
  - When match_cnt reaches LOCK_CNT: go to LOCK, locked<=1, win_cnt=0, win_err=0.
- LOCK:
  - H <= {p, H[4:1]}. The predicted bit is shifted in, not bit_in, so a single bit error produces exactly one error.
  - If bit_in != p: err_pulse<=1, err_count++ (saturates at all-ones), win_err++.
  - win_cnt counts 0..30 and wraps. On wrap, win_err is cleared, unless that same bit makes win_err reach UNLOCK_ERR.
  - When win_err reaches UNLOCK_ERR: go to FILL next cycle, locked<=0, H=0, fill_cnt=0. err_count is retained.
- Errors are counted only in LOCK. HUNT/FILL mismatches never touch err_count or err_pulse.
- clr_cnt=1 sets err_count to 0 and has priority over a simultaneous increment. Lock state is unaffected.
- bit_valid low: state, H and counters hold. Gaps of any length are allowed.
- Reset mid-operation: immediate return to reset values, regardless of state.
- Lock latency from reset, error-free stream: locked rises on the clock after the (5+LOCK_CNT)th valid bit, i.e. 13 bits by default.

Optional Feature:
- Macro PRBS5_CHECKER_STATS_EN.
- Defined: adds output bit_count [31:0], a wrapping count of valid bits received while locked.
  - Cleared by reset and by clr_cnt; clr_cnt wins over a same-cycle increment.
  - Holds across loss of lock.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Clean lock: reset, then feed the generator's bit-0 stream (seed 00001: 1,0,0,0,0,1,0,...) with bit_valid=1 every cycle → locked=1 after bit 13; err_count stays 0 over 1000 bits.
- Single error: after lock, invert one bit → exactly one err_pulse, err_count=1, locked stays 1, following bits produce no errors.
- Loss of lock: after lock, invert 4 bits within 31 bits → locked=0 on the clock after the 4th error; clean stream then relocks 13 bits later; err_count=4 retained.
- All-zero / gappy input: 200 zero bits → never locks. A clean stream with bit_valid toggling 1,0 → locks after 13 valid bits, no errors.
- Saturation and clear: ERR_CNT_W=4, inject 20 sparse errors (≤3 per window) → err_count=15. Assert clr_cnt in the same cycle as an error → err_count=0.
- Async reset while locked: drop arst_n mid-cycle → locked, err_pulse, err_count go to 0 immediately; relock after 13 clean bits.

Source files
------------

// File: rtl/prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs5_checker
// Purpose  : Serial receive-side checker for the x^5+x^2+1 (period 31)
//            pattern. Self-synchronises to the incoming stream, declares
//            lock, then counts bit errors against a free-running local
//            prediction. Intended for BER measurement at the end of a
//            loopback or serial-link path.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   arst_n     in   asynchronous active-low reset
//   bit_valid  in   bit_in is sampled on this cycle when high
//   bit_in     in   received serial bit
//   clr_cnt    in   synchronous clear of err_count (and bit_count)
//   locked     out  registered, high while in LOCK
//   err_pulse  out  registered one-cycle pulse per errored bit while locked
//   err_count  out  [ERR_CNT_W] saturating error counter
//   bit_count  out  [32] wrapping count of valid bits received while locked
//                   (present only when PRBS5_CHECKER_STATS_EN is defined)
// Parameters
//   BITWIDTH   history register width, 5 for this polynomial
//   LOCK_CNT   consecutive good predictions in HUNT needed to lock (1..255)
//   UNLOCK_ERR errors in one 31-bit LOCK window that drop lock (1..31)
//   ERR_CNT_W  err_count width
// Optional feature macro
//   PRBS5_CHECKER_STATS_EN : adds the bit_count output and its counter
// ============================================================================
module prbs5_checker #(
  parameter int BITWIDTH   = 5,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PRBS5_CHECKER_STATS_EN
  ,
  output logic [31:0]          bit_count
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_fill_last  = 3'd4;            // 5th bit of FILL
  localparam logic [4:0] c_win_last   = 5'd30;           // last bit of window
  localparam logic [7:0] c_lock_cnt   = 8'(LOCK_CNT);
  localparam logic [4:0] c_unlock_err = 5'(UNLOCK_ERR);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [BITWIDTH-1:0]  h_q,         h_d;          // h[4] newest, h[0] oldest
  logic [2:0]           fill_cnt_q,  fill_cnt_d;
  logic [7:0]           match_cnt_q, match_cnt_d;
  logic [4:0]           win_cnt_q,   win_cnt_d;
  logic [4:0]           win_err_q,   win_err_d;
  logic                 locked_q,    locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 w_pred;          // predicted next stream bit
  logic                 w_bit_err;       // received bit disagrees while locked
  logic [7:0]           w_match_nxt;     // HUNT run length including this bit
  logic [4:0]           w_win_err_nxt;   // window errors including this bit

  // b[n] = b[n-3] ^ b[n-5]; with h[4]=b[n-1] .. h[0]=b[n-5]
  assign w_pred = h_q[2] ^ h_q[0];

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    fill_cnt_d    = fill_cnt_q;
    match_cnt_d   = match_cnt_q;
    win_cnt_d     = win_cnt_q;
    win_err_d     = win_err_q;
    locked_d      = locked_q;
    err_pulse_d   = 1'b0;          // pulse is only ever one cycle wide
    err_count_d   = err_count_q;
    w_bit_err     = 1'b0;
    w_match_nxt   = match_cnt_q;
    w_win_err_nxt = win_err_q;

    if (bit_valid) begin
      unique case (state_q)
        // ---------------------------------------------------------------
        // Load five raw bits into the history before trying to predict.
        // ---------------------------------------------------------------
        ST_FILL: begin
          h_d = {bit_in, h_q[BITWIDTH-1:1]};
          if (fill_cnt_q == c_fill_last) begin
            state_d     = ST_HUNT;
            fill_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
          end else begin
            fill_cnt_d  = fill_cnt_q + 3'd1;
          end
        end

        // ---------------------------------------------------------------
        // Follow the received stream and count consecutive good
        // predictions. An all-zero history trivially predicts zero, so a
        // dead (all-zero) line is never allowed to build up a run.
        // ---------------------------------------------------------------
        ST_HUNT: begin
          h_d = {bit_in, h_q[BITWIDTH-1:1]};
          if ((bit_in == w_pred) && (h_q != '0)) begin
            w_match_nxt = match_cnt_q + 8'd1;
          end else begin
            w_match_nxt = 8'd0;
          end

          if (w_match_nxt == c_lock_cnt) begin
            state_d     = ST_LOCK;
            locked_d    = 1'b1;
            win_cnt_d   = 5'd0;
            win_err_d   = 5'd0;
            match_cnt_d = 8'd0;
          end else begin
            match_cnt_d = w_match_nxt;
          end
        end

        // ---------------------------------------------------------------
        // Free-run on the local prediction: the received bit never enters
        // the history, so one flipped line bit yields exactly one error
        // instead of three (it would otherwise poison two later taps).
        // ---------------------------------------------------------------
        ST_LOCK: begin
          h_d           = {w_pred, h_q[BITWIDTH-1:1]};
          w_bit_err     = (bit_in != w_pred);
          w_win_err_nxt = win_err_q + {4'd0, w_bit_err};

          if (w_bit_err) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
          end

          // Loss of lock takes priority over the window wrap so that an
          // error on the last bit of a window still counts toward it.
          if (w_win_err_nxt == c_unlock_err) begin
            state_d    = ST_FILL;
            locked_d   = 1'b0;
            h_d        = '0;
            fill_cnt_d = 3'd0;
            win_cnt_d  = 5'd0;
            win_err_d  = 5'd0;
          end else if (win_cnt_q == c_win_last) begin
            win_cnt_d  = 5'd0;
            win_err_d  = 5'd0;
          end else begin
            win_cnt_d  = win_cnt_q + 5'd1;
            win_err_d  = w_win_err_nxt;
          end
        end

        default: begin
          // Unreachable encoding: restart synchronisation cleanly.
          state_d     = ST_FILL;
          h_d         = '0;
          fill_cnt_d  = 3'd0;
          match_cnt_d = 8'd0;
          win_cnt_d   = 5'd0;
          win_err_d   = 5'd0;
          locked_d    = 1'b0;
        end
      endcase
    end

    // Clear is independent of bit_valid and beats a same-cycle increment.
    if (clr_cnt) begin
      err_count_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_FILL;
      h_q         <= '0;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= 5'd0;
      win_err_q   <= 5'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef PRBS5_CHECKER_STATS_EN
  // --------------------------------------------------------------------------
  // Locked-bit statistics: wraps freely and is kept across loss of lock so
  // software can form a BER ratio against err_count.
  // --------------------------------------------------------------------------
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (bit_valid && (state_q == ST_LOCK)) begin
      bit_count_d = bit_count_q + 32'd1;
    end
    if (clr_cnt) begin
      bit_count_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_count_q <= 32'd0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs5_checker
// Purpose  : Self-checking bench for prbs5_checker. A table of stream
//            segments drives the checker; every driven cycle pushes the
//            expected outputs of an independent behavioural model into a
//            scoreboard queue, which is popped and compared on the falling
//            edge. Segment-end expectations from the table are compared too.
//            Hand-written sequences cover async reset while locked, long
//            bit_valid gaps and clr_cnt without bit_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs5_checker;

  localparam int ERR_W   = 4;
  localparam int LOCK_N  = 8;
  localparam int UNLOCK  = 4;
  localparam int SAT_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             arst_n;
  logic             bit_valid;
  logic             bit_in;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
`ifdef PRBS5_CHECKER_STATS_EN
  logic [31:0]      bit_count;
`endif

  prbs5_checker #(
    .BITWIDTH   (5),
    .LOCK_CNT   (LOCK_N),
    .UNLOCK_ERR (UNLOCK),
    .ERR_CNT_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef PRBS5_CHECKER_STATS_EN
    ,
    .bit_count (bit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // --------------------------------------------------------------------------
  // Pattern generator: 5-bit LFSR, seed 00001, serial output = state bit 0
  // --------------------------------------------------------------------------
  logic [4:0] g_s;

  function automatic bit gen_bit();
    bit b;
    b   = g_s[0];
    g_s = {g_s[2] ^ g_s[0], g_s[4:1]};
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural reference model
  // --------------------------------------------------------------------------
  typedef enum int {M_FILL, M_HUNT, M_LOCK} mstate_t;
  mstate_t     m_st;
  logic [4:0]  m_h;
  int          m_fill, m_match, m_win, m_werr, m_cnt;
  bit          m_locked, m_pulse;
  logic [31:0] m_bits;

  function automatic void model_reset();
    m_st = M_FILL; m_h = '0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_cnt = 0; m_locked = 0; m_pulse = 0; m_bits = '0;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit clr);
    bit pred;
    m_pulse = 0;
    if (v) begin
      pred = m_h[2] ^ m_h[0];
      case (m_st)
        M_FILL: begin
          m_h = {b, m_h[4:1]};
          m_fill++;
          if (m_fill == 5) begin m_st = M_HUNT; m_fill = 0; m_match = 0; end
        end
        M_HUNT: begin
          m_match = (b == pred && m_h != 0) ? m_match + 1 : 0;
          m_h = {b, m_h[4:1]};
          if (m_match == LOCK_N) begin
            m_st = M_LOCK; m_locked = 1; m_win = 0; m_werr = 0;
          end
        end
        default: begin
          m_bits++;
          m_h = {pred, m_h[4:1]};
          if (b != pred) begin
            m_pulse = 1;
            m_werr++;
            if (m_cnt < SAT_MAX) m_cnt++;
          end
          if (m_werr >= UNLOCK) begin
            m_st = M_FILL; m_locked = 0; m_h = '0; m_fill = 0; m_win = 0; m_werr = 0;
          end else if (m_win == 30) begin
            m_win = 0; m_werr = 0;
          end else begin
            m_win++;
          end
        end
      endcase
    end
    if (clr) begin m_cnt = 0; m_bits = '0; end
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard and comparison helpers
  // --------------------------------------------------------------------------
  typedef struct {
    bit          locked;
    bit          pulse;
    int          cnt;
    logic [31:0] bits;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle from the falling edge, sample results on the next one.
  task automatic step(input bit v, input bit b, input bit clr);
    exp_t e;
    bit_valid = v; bit_in = b; clr_cnt = clr;
    @(posedge clk);
    model_step(v, b, clr);
    e.locked = m_locked; e.pulse = m_pulse; e.cnt = m_cnt; e.bits = m_bits;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("locked", longint'(locked), longint'(e.locked));
      check("err_pulse", longint'(err_pulse), longint'(e.pulse));
      check("err_count", longint'(err_count), longint'(e.cnt));
`ifdef PRBS5_CHECKER_STATS_EN
      check("bit_count", longint'(bit_count), longint'(e.bits));
`endif
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_locked", longint'(locked), 0);
    check("rst_err_pulse", longint'(err_pulse), 0);
    check("rst_err_count", longint'(err_count), 0);
    arst_n = 1'b1;
    model_reset();
    g_s = 5'b00001;
    sb_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // Segment table
  // --------------------------------------------------------------------------
  typedef struct {
    bit rst;        // reset before the segment
    int nbits;      // cycles in the segment
    bit toggle;     // bit_valid alternates 1,0 (else always 1)
    bit zeros;      // drive all-zero data instead of the pattern
    int inv_start;  // first inverted cycle index
    int inv_step;   // spacing of inversions
    int inv_num;    // number of inversions
    int clr_at;     // cycle index with clr_cnt=1, -1 for none
    bit exp_locked; // locked at end of segment
    int exp_cnt;    // err_count at end of segment
  } seg_t;

  task automatic apply_seg(input seg_t s, input int idx);
    int  inv_k;
    bit  v, b, c;
    inv_k = 0;
    if (s.rst) do_reset();
    for (int i = 0; i < s.nbits; i++) begin
      v = s.toggle ? (i % 2 == 0) : 1'b1;
      if (!v) begin
        b = 1'($urandom_range(0, 1));
      end else if (s.zeros) begin
        b = 1'b0;
      end else begin
        b = gen_bit();
        if (inv_k < s.inv_num && i == s.inv_start + inv_k * s.inv_step) begin
          b = ~b;
          inv_k++;
        end
      end
      c = (i == s.clr_at);
      step(v, b, c);
    end
    check($sformatf("seg%0d_locked", idx), longint'(locked), longint'(s.exp_locked));
    check($sformatf("seg%0d_err_count", idx), longint'(err_count), longint'(s.exp_cnt));
  endtask

  seg_t tbl[13];
  seg_t hs;

  initial begin
    arst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
    g_s = 5'b00001;
    model_reset();

    //          rst nbits tog zer ist stp num clr lck cnt
    tbl[0]  = '{1,  12,   0,  0,  0,  1,  0,  -1, 0,  0};  // one bit short of lock
    tbl[1]  = '{0,  1,    0,  0,  0,  1,  0,  -1, 1,  0};  // 13th bit locks
    tbl[2]  = '{0,  1000, 0,  0,  0,  1,  0,  -1, 1,  0};  // long clean run
    tbl[3]  = '{0,  40,   0,  0,  5,  1,  1,  -1, 1,  1};  // single error
    tbl[4]  = '{0,  10,   0,  0,  0,  3,  4,  -1, 0,  5};  // 4 errors -> unlock
    tbl[5]  = '{0,  12,   0,  0,  0,  1,  0,  -1, 0,  5};  // relocking
    tbl[6]  = '{0,  1,    0,  0,  0,  1,  0,  -1, 1,  5};  // relocked, count kept
    tbl[7]  = '{0,  400,  0,  0,  0,  20, 20, -1, 1,  SAT_MAX}; // saturate
    tbl[8]  = '{0,  10,   0,  0,  2,  1,  1,  2,  1,  0};  // clr with error
    tbl[9]  = '{0,  10,   0,  0,  3,  1,  1,  -1, 1,  1};  // counting resumes
    tbl[10] = '{1,  200,  0,  1,  0,  1,  0,  -1, 0,  0};  // all zeros never lock
    tbl[11] = '{1,  24,   1,  0,  0,  1,  0,  -1, 0,  0};  // gappy, 12 valid bits
    tbl[12] = '{0,  2,    1,  0,  0,  1,  0,  -1, 1,  0};  // 13th valid bit locks

    for (int k = 0; k < 13; k++) begin
      apply_seg(tbl[k], k);
    end

    // Async reset while locked with an error pulse outstanding.
    step(1'b1, ~gen_bit(), 1'b0);
    check("pre_rst_pulse", longint'(err_pulse), 1);
    check("pre_rst_count", longint'(err_count), 1);
    #2 arst_n = 1'b0;
    #1;
    check("async_locked", longint'(locked), 0);
    check("async_err_pulse", longint'(err_pulse), 0);
    check("async_err_count", longint'(err_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    g_s = 5'b00001;
    sb_q.delete();

    hs = '{0, 12, 0, 0, 0, 1, 0, -1, 0, 0};
    apply_seg(hs, 100);
    hs = '{0, 1, 0, 0, 0, 1, 0, -1, 1, 0};
    apply_seg(hs, 101);

    // Long gap: everything holds while bit_valid is low.
    repeat (50) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check("gap_locked", longint'(locked), 1);
    // Stream resumes in phase after the gap; one error, then clr without valid.
    step(1'b1, ~gen_bit(), 1'b0);
    check("gap_err_count", longint'(err_count), 1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_novalid_count", longint'(err_count), 0);
    check("clr_novalid_locked", longint'(locked), 1);
    repeat (40) step(1'b1, gen_bit(), 1'b0);
    check("post_clr_count", longint'(err_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
